int_ctrl: RTL and testbench

INT_CTRL -- requirements
Module: int_ctrl

---
 rtl/int_ctrl_pkg.sv | 31 +++
 rtl/int_ctrl.sv | 142 ++++++++++++++
 tb/tb_int_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/int_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : int_ctrl_pkg
// Description : Shared definitions for the interrupt controller: FSM state
//               encoding, machine-mode CSR addresses and mcause codes.
// Revision    : 1.0 - initial release
// ============================================================================
package int_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_W_MEPC    = 3'd1,
        ST_W_MCAUSE  = 3'd2,
        ST_W_MSTATUS = 3'd3,
        ST_W_MRET    = 3'd4,
        ST_JUMP      = 3'd5
    } state_t;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [31:0] MCAUSE_INT      = 32'h8000_0000;
    localparam logic [31:0] MCAUSE_TIMER    = 32'h8000_0007;
    localparam int          MCAUSE_EXT_BASE = 16;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

endpackage : int_ctrl_pkg
`default_nettype wire

// File: rtl/int_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : int_ctrl
// Description : Machine-mode interrupt controller. Takes the lowest-index
//               pending level interrupt when MIE is set, sequences the
//               mepc/mcause/mstatus CSR writes and redirects the PC to mtvec.
//               Also sequences MRET (mstatus restore, jump to mepc).
// Revision    : 1.0 - initial release
// ============================================================================
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int INT_SRC_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [INT_SRC_W-1:0] int_flag_i,
    input  logic                 inst_valid_i,
    input  logic [31:0]          inst_addr_i,
    input  logic                 mret_i,
    input  logic [31:0]          csr_mstatus_i,
    input  logic [31:0]          csr_mtvec_i,
    input  logic [31:0]          csr_mepc_i,
    output logic                 csr_we_o,
    output logic [11:0]          csr_waddr_o,
    output logic [31:0]          csr_wdata_o,
    output logic                 hold_o,
    output logic                 int_jump_o,
    output logic [31:0]          int_addr_o,
    output logic [INT_SRC_W-1:0] int_ack_o
);

    localparam int SRC_IDX_W = (INT_SRC_W > 1) ? $clog2(INT_SRC_W) : 1;

    // Lowest-index set bit wins; scanning downward leaves the lowest hit last.
    function automatic logic [SRC_IDX_W-1:0] lowest_set(input logic [INT_SRC_W-1:0] v);
        lowest_set = '0;
        for (int i = INT_SRC_W - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = SRC_IDX_W'(i);
        end
    endfunction

    state_t               state;
    logic [31:0]          saved_pc;
    logic [SRC_IDX_W-1:0] source;
    logic                 ret_jump;     // JUMP targets mepc (MRET) rather than mtvec
    logic                 take_int;
    logic                 take_mret;
    logic [31:0]          mstatus_new;

    // Interrupts are only sampled in IDLE; an interrupt beats a coincident MRET.
    assign take_int  = (state == ST_IDLE) && inst_valid_i && csr_mstatus_i[MSTATUS_MIE]
                       && (|int_flag_i);
    assign take_mret = (state == ST_IDLE) && inst_valid_i && mret_i && !take_int;

    // Sequence state, saved PC and taken source.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            saved_pc <= '0;
            source   <= '0;
            ret_jump <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (take_int) begin
                        saved_pc <= inst_addr_i;
                        source   <= lowest_set(int_flag_i);
                        ret_jump <= 1'b0;
                        state    <= ST_W_MEPC;
                    end else if (take_mret) begin
                        ret_jump <= 1'b1;
                        state    <= ST_W_MRET;
                    end
                end
                ST_W_MEPC:    state <= ST_W_MCAUSE;
                ST_W_MCAUSE:  state <= ST_W_MSTATUS;
                ST_W_MSTATUS: state <= ST_JUMP;
                ST_W_MRET:    state <= ST_JUMP;
                ST_JUMP:      state <= ST_IDLE;
                default:      state <= ST_IDLE;
            endcase
        end
    end

    // Output decode; CSR write data uses the live CSR values of the write cycle.
    always_comb begin
        hold_o      = 1'b0;
        csr_we_o    = 1'b0;
        csr_waddr_o = '0;
        csr_wdata_o = '0;
        int_jump_o  = 1'b0;
        int_addr_o  = '0;
        int_ack_o   = '0;
        mstatus_new = csr_mstatus_i;
        case (state)
            ST_IDLE: begin
                hold_o = take_int || take_mret;
            end
            ST_W_MEPC: begin
                hold_o      = 1'b1;
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MEPC;
                csr_wdata_o = saved_pc;
                int_ack_o   = INT_SRC_W'(1) << source;
            end
            ST_W_MCAUSE: begin
                hold_o      = 1'b1;
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MCAUSE;
                csr_wdata_o = (source == '0) ? MCAUSE_TIMER
                            : (MCAUSE_INT | 32'(MCAUSE_EXT_BASE + int'(source)));
            end
            ST_W_MSTATUS: begin
                mstatus_new[MSTATUS_MPIE] = csr_mstatus_i[MSTATUS_MIE];
                mstatus_new[MSTATUS_MIE]  = 1'b0;
                hold_o      = 1'b1;
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MSTATUS;
                csr_wdata_o = mstatus_new;
            end
            ST_W_MRET: begin
                mstatus_new[MSTATUS_MIE]  = csr_mstatus_i[MSTATUS_MPIE];
                mstatus_new[MSTATUS_MPIE] = 1'b1;
                hold_o      = 1'b1;
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MSTATUS;
                csr_wdata_o = mstatus_new;
            end
            ST_JUMP: begin
                hold_o     = 1'b1;
                int_jump_o = 1'b1;
                int_addr_o = ret_jump ? csr_mepc_i : {csr_mtvec_i[31:2], 2'b00};
            end
            default: begin
                hold_o = 1'b0;
            end
        endcase
    end

endmodule : int_ctrl
`default_nettype wire

// File: tb/tb_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_int_ctrl
// Description : Self-checking bench for int_ctrl. A behavioural model keeps a
//               script of pending actions (write mepc, write mcause, ...) and
//               predicts every output each cycle from the current inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_int_ctrl;

    localparam int INT_SRC_W = 8;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [INT_SRC_W-1:0] int_flag;
    logic                 inst_valid;
    logic [31:0]          inst_addr;
    logic                 mret;
    logic [31:0]          csr_mstatus;
    logic [31:0]          csr_mtvec;
    logic [31:0]          csr_mepc;
    logic                 csr_we;
    logic [11:0]          csr_waddr;
    logic [31:0]          csr_wdata;
    logic                 hold;
    logic                 int_jump;
    logic [31:0]          int_addr;
    logic [INT_SRC_W-1:0] int_ack;

    int checks = 0;
    int passed = 0;
    int failed = 0;
    int cyc    = 0;

    // Model: queue of pending actions
    // 1 write mepc, 2 write mcause, 3 write mstatus (trap), 4 write mstatus (mret),
    // 5 jump to mtvec, 6 jump to mepc
    int          mq[$];
    logic [31:0] m_pc;
    int          m_src;

    int_ctrl #(.INT_SRC_W(INT_SRC_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .int_flag_i   (int_flag),
        .inst_valid_i (inst_valid),
        .inst_addr_i  (inst_addr),
        .mret_i       (mret),
        .csr_mstatus_i(csr_mstatus),
        .csr_mtvec_i  (csr_mtvec),
        .csr_mepc_i   (csr_mepc),
        .csr_we_o     (csr_we),
        .csr_waddr_o  (csr_waddr),
        .csr_wdata_o  (csr_wdata),
        .hold_o       (hold),
        .int_jump_o   (int_jump),
        .int_addr_o   (int_addr),
        .int_ack_o    (int_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s cyc=%0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // One clock: drive at negedge, predict and compare, then advance the model.
    task automatic step(input logic v, input logic [31:0] pc, input logic mr,
                        input logic [7:0] fl, input logic [31:0] ms,
                        input logic [31:0] mt, input logic [31:0] me, input logic rn);
        logic        e_hold, e_we, e_jump, t_int, t_mret;
        logic [11:0] e_waddr;
        logic [31:0] e_wdata, e_addr;
        logic [7:0]  e_ack;
        int          act, lo;
        @(negedge clk);
        cyc++;
        inst_valid = v; inst_addr = pc; mret = mr; int_flag = fl;
        csr_mstatus = ms; csr_mtvec = mt; csr_mepc = me; rst_n = rn;
        #1;
        e_hold = 0; e_we = 0; e_jump = 0; e_waddr = 0; e_wdata = 0; e_addr = 0; e_ack = 0;
        t_int = 0; t_mret = 0;
        if (mq.size() != 0) begin
            act    = mq[0];
            e_hold = 1;
            case (act)
                1: begin e_we = 1; e_waddr = 12'h341; e_wdata = m_pc; e_ack = 8'(1 << m_src); end
                2: begin
                    e_we = 1; e_waddr = 12'h342;
                    e_wdata = (m_src == 0) ? 32'h8000_0007 : (32'h8000_0000 + 32'(16 + m_src));
                end
                3: begin e_we = 1; e_waddr = 12'h300; e_wdata = (ms & ~32'h88) | ((ms & 32'h08) << 4); end
                4: begin e_we = 1; e_waddr = 12'h300; e_wdata = (ms & ~32'h88) | ((ms & 32'h80) >> 4) | 32'h80; end
                5: begin e_jump = 1; e_addr = mt & ~32'h3; end
                default: begin e_jump = 1; e_addr = me; end
            endcase
        end else begin
            t_int  = v && ms[3] && (fl != 0);
            t_mret = v && mr && !t_int;
            e_hold = t_int || t_mret;
        end
        chk("hold",  32'(hold),      32'(e_hold));
        chk("we",    32'(csr_we),    32'(e_we));
        chk("waddr", 32'(csr_waddr), 32'(e_waddr));
        chk("wdata", csr_wdata,      e_wdata);
        chk("jump",  32'(int_jump),  32'(e_jump));
        chk("addr",  int_addr,       e_addr);
        chk("ack",   32'(int_ack),   32'(e_ack));
        if (!rn) begin
            mq.delete();
        end else if (mq.size() != 0) begin
            void'(mq.pop_front());
        end else if (t_int) begin
            lo = -1;
            for (int i = 0; i < 8; i++) if (fl[i] && lo < 0) lo = i;
            m_pc  = pc;
            m_src = lo;
            mq    = '{1, 2, 3, 5};
        end else if (t_mret) begin
            mq = '{4, 6};
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(0, 32'h0, 0, 8'h00, 32'h0, 32'h0, 32'h0, 1);
    endtask

    initial begin
        // Initial reset (state unknown before the first edge, so not compared)
        rst_n = 0; inst_valid = 0; inst_addr = 0; mret = 0; int_flag = 0;
        csr_mstatus = 0; csr_mtvec = 0; csr_mepc = 0;
        repeat (2) @(posedge clk);
        step(0, 32'h0, 0, 8'h00, 32'h0, 32'h0, 32'h0, 0);
        idle_cycles(2);

        // Timer interrupt
        step(1, 32'h0000_0100, 0, 8'h01, 32'h08, 32'h0000_0404, 32'h0, 1);
        chk("d_timer_hold_T", 32'(hold), 32'd1);
        step(0, 32'h0, 0, 8'h00, 32'h08, 32'h0000_0404, 32'h0, 1);
        chk("d_timer_mepc", csr_wdata, 32'h0000_0100);
        step(0, 32'h0, 0, 8'h00, 32'h08, 32'h0000_0404, 32'h0, 1);
        chk("d_timer_mcause", csr_wdata, 32'h8000_0007);
        step(0, 32'h0, 0, 8'h00, 32'h08, 32'h0000_0404, 32'h0, 1);
        chk("d_timer_mstatus", csr_wdata, 32'h0000_0080);
        step(0, 32'h0, 0, 8'h00, 32'h08, 32'h0000_0404, 32'h0, 1);
        chk("d_timer_jump", int_addr, 32'h0000_0404);
        idle_cycles(1);

        // Priority: flags 0x0A -> source 1
        step(1, 32'h0000_0400, 0, 8'h0A, 32'h08, 32'h0000_1000, 32'h0, 1);
        step(0, 32'h0, 0, 8'hFF, 32'h08, 32'h0000_1000, 32'h0, 1);
        chk("d_prio_ack", 32'(int_ack), 32'h02);
        step(1, 32'h0, 1, 8'h01, 32'h08, 32'h0000_1000, 32'h0, 1);
        chk("d_prio_mcause", csr_wdata, 32'h8000_0011);
        step(0, 32'h0, 0, 8'h00, 32'h08, 32'h0000_1000, 32'h0, 1);
        step(0, 32'h0, 0, 8'h00, 32'h08, 32'h0000_1003, 32'h0, 1);
        chk("d_prio_jump", int_addr, 32'h0000_1000);
        idle_cycles(1);

        // Masked: MIE clear, all requests pending
        for (int i = 0; i < 20; i++) step(1, 32'h0000_0800, 0, 8'hFF, 32'h0, 32'h4, 32'h0, 1);

        // MRET
        step(1, 32'h0000_0900, 1, 8'h00, 32'h80, 32'h0, 32'h0000_0200, 1);
        chk("d_mret_hold", 32'(hold), 32'd1);
        step(0, 32'h0, 0, 8'h00, 32'h80, 32'h0, 32'h0000_0200, 1);
        chk("d_mret_mstatus", csr_wdata, 32'h0000_0088);
        step(0, 32'h0, 0, 8'h00, 32'h88, 32'h0, 32'h0000_0200, 1);
        chk("d_mret_jump", int_addr, 32'h0000_0200);
        idle_cycles(1);

        // Collision: MRET and timer interrupt together
        step(1, 32'h0000_0300, 1, 8'h01, 32'h88, 32'h0000_0040, 32'h0000_0200, 1);
        step(0, 32'h0, 0, 8'h00, 32'h88, 32'h0000_0040, 32'h0000_0200, 1);
        chk("d_coll_mepc", csr_wdata, 32'h0000_0300);
        idle_cycles(4);

        // Reset at W_MCAUSE
        step(1, 32'h0000_0500, 0, 8'h04, 32'h08, 32'h0000_0040, 32'h0, 1);
        step(0, 32'h0, 0, 8'h00, 32'h08, 32'h0000_0040, 32'h0, 1);
        step(0, 32'h0, 0, 8'h00, 32'h08, 32'h0000_0040, 32'h0, 0);
        step(1, 32'h0, 0, 8'h00, 32'h08, 32'h0000_0040, 32'h0, 1);
        chk("d_rst_we", 32'(csr_we), 32'd0);
        chk("d_rst_hold", 32'(hold), 32'd0);
        idle_cycles(4);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 3) == 0,
                 ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom),
                 $urandom, $urandom, $urandom, $urandom_range(0, 40) != 0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule : tb_int_ctrl
`default_nettype wire
